// File: rtl/display_pkg.sv
// Shared display constants for the 40x30 monochrome framebuffer and its VGA scan-out.
// The glyph renderers import this package too, so geometry lives here only.
package display_pkg;
    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int FB_BITS    = COLS * ROWS;
    localparam int CELL_SHIFT = 4;
    localparam int CNT_W      = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t FG_COLOR = 12'hFFF;
    localparam rgb444_t BG_COLOR = 12'h000;

    // row*40 + col without a multiplier: (row<<5) + (row<<3) + col.
    function automatic logic [10:0] fb_index(input logic [4:0] row, input logic [5:0] col);
        logic [10:0] w_row_ext;
        w_row_ext = {6'd0, row};
        return (w_row_ext << 5) + (w_row_ext << 3) + {5'd0, col};
    endfunction
endpackage

// File: rtl/vga_timing.sv
// Pixel-clock enable plus horizontal/vertical counters and raw sync/active decode.
// Counters step only on clocks where pix_ce is high (25 MHz from the 50 MHz clock).
module vga_timing
    import display_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             pix_ce,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             vblank_start
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(P_H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(P_V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(P_H_ACTIVE + P_H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(P_V_ACTIVE + P_V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

    logic             r_pix_ce;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_ce <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
        end else begin
            r_pix_ce <= ~r_pix_ce;
            if (r_pix_ce) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign pix_ce       = r_pix_ce;
    assign h            = r_h;
    assign v            = r_v;
    assign active       = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign hs_raw       = !((r_h >= HS_START) && (r_h < HS_END));
    assign vs_raw       = !((r_v >= VS_START) && (r_v < VS_END));
    assign vblank_start = (r_h == '0) && (r_v == V_ACT_C);
endmodule

// File: rtl/vga_scanout.sv
// Scans the framebuffer out as VGA: a per-frame snapshot taken at vblank start keeps
// writers from tearing the picture; colour and syncs share one output register stage.
module vga_scanout
    import display_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [FB_BITS-1:0] framebuffer,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               frame_start
);
    logic             w_pix_ce;
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_active;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_vblank_start;
    logic [4:0]       w_row;
    logic [5:0]       w_col;
    logic [10:0]      w_idx;
    logic             w_bit;
    rgb444_t          w_color;

    logic [FB_BITS-1:0] r_snap;
    rgb444_t            r_rgb;
    logic               r_hs;
    logic               r_vs;
    logic               r_fs;

    vga_timing #(
        .P_H_ACTIVE(P_H_ACTIVE), .P_H_FP(P_H_FP), .P_H_SYNC(P_H_SYNC), .P_H_BP(P_H_BP),
        .P_V_ACTIVE(P_V_ACTIVE), .P_V_FP(P_V_FP), .P_V_SYNC(P_V_SYNC), .P_V_BP(P_V_BP)
    ) u_timing (
        .clock       (clock),
        .reset_n     (reset_n),
        .pix_ce      (w_pix_ce),
        .h           (w_h),
        .v           (w_v),
        .active      (w_active),
        .hs_raw      (w_hs_raw),
        .vs_raw      (w_vs_raw),
        .vblank_start(w_vblank_start)
    );

    // Outside the active area the index can exceed 1199; the result is masked below.
    assign w_row   = 5'(w_v >> CELL_SHIFT);
    assign w_col   = 6'(w_h >> CELL_SHIFT);
    assign w_idx   = fb_index(w_row, w_col);
    assign w_bit   = r_snap[w_idx];
    assign w_color = w_active ? (w_bit ? FG_COLOR : BG_COLOR) : 12'h000;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= '0;
            r_rgb  <= 12'h000;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_fs   <= 1'b0;
        end else begin
            r_fs <= w_pix_ce && w_vblank_start;
            if (w_pix_ce) begin
                r_rgb <= w_color;
                r_hs  <= w_hs_raw;
                r_vs  <= w_vs_raw;
                if (w_vblank_start) begin
                    r_snap <= framebuffer;
                end
            end
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (48x32 active) so several frames fit in a short run.
// A time-based reference model predicts every output on every clock.
module tb_vga_scanout;
  import display_pkg::*;

  localparam int HA = 48, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 32, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = 2 * HT * VT;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [FB_BITS-1:0] framebuffer = '0;
  logic [3:0]         vga_r, vga_g, vga_b;
  logic               vga_hs, vga_vs, frame_start;

  int tests = 0;
  int fails = 0;
  int fail_prints = 0;

  // ---------------- clock / reset ----------------
  always #10 clock = ~clock;

  initial begin
    #(120000 * 20);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vga_scanout #(
    .P_H_ACTIVE(HA), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
    .P_V_ACTIVE(VA), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .framebuffer(framebuffer),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- reference model ----------------
  // k = clock edges since reset release. After edge k (k>=2) the outputs show
  // screen pixel number k/2-1 of the raster; snapshot follows each frame_start.
  int unsigned        k = 0;
  logic [FB_BITS-1:0] m_snap = '0;

  function automatic bit fs_at(input int unsigned kk);
    int p;
    if (kk < 2 || (kk % 2) != 0) return 1'b0;
    p = kk / 2 - 1;
    return ((p % HT) == 0) && (((p / HT) % VT) == VA);
  endfunction

  function automatic logic [14:0] exp_vec(input int unsigned kk, input logic [FB_BITS-1:0] s);
    int p, h, v;
    logic [11:0] rgb;
    logic hs, vs;
    if (kk < 2) return {12'h000, 1'b1, 1'b1, 1'b0};
    p = kk / 2 - 1;
    h = p % HT;
    v = (p / HT) % VT;
    rgb = 12'h000;
    if (h < HA && v < VA) rgb = s[(v / 16) * COLS + (h / 16)] ? 12'hFFF : 12'h000;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    return {rgb, hs, vs, fs_at(kk)};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k <= 0;
      m_snap <= '0;
    end else begin
      k <= k + 1;
      if (fs_at(k + 1)) m_snap <= framebuffer;
    end
  end

  // ---------------- scoreboard: every clock against the model ----------------
  always @(negedge clock) begin
    check("scan", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start}), 32'(exp_vec(k, m_snap)));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pixel(input int h, input int v);
    int n;
    int p;
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 2 * FRAME_CLK) begin
      @(negedge clock);
      n++;
      if (k >= 2) begin
        p = k / 2 - 1;
        hit = ((p % HT) == h) && (((p / HT) % VT) == v);
      end
    end
    if (!hit) check("wait_pixel_timeout", 0, 1);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME_CLK);
    if (frame_start !== 1'b1) check("wait_fs_timeout", 0, 1);
  endtask

  // Counts white clocks up to (not including) the next frame_start.
  task automatic count_until_fs(output int white);
    int n;
    white = 0;
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (frame_start === 1'b1) break;
      if ({vga_r, vga_g, vga_b} === 12'hFFF) white++;
      if (n >= 2 * FRAME_CLK) begin
        check("count_fs_timeout", 0, 1);
        break;
      end
    end
  endtask

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
  } probe_t;

  probe_t probes[11];

  initial begin
    int n, lo, hi, white;

    probes[0]  = '{0, 0, 12'hFFF};
    probes[1]  = '{16, 0, 12'h000};
    probes[2]  = '{15, 15, 12'hFFF};
    probes[3]  = '{47, 15, 12'h000};
    probes[4]  = '{0, 16, 12'h000};
    probes[5]  = '{15, 16, 12'h000};
    probes[6]  = '{16, 16, 12'hFFF};
    probes[7]  = '{32, 16, 12'hFFF};
    probes[8]  = '{31, 31, 12'hFFF};
    probes[9]  = '{47, 31, 12'hFFF};
    probes[10] = '{48, 31, 12'h000};

    // Reset state
    repeat (5) @(posedge clock);
    #1;
    check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
    check("reset_hs", 32'(vga_hs), 32'd1);
    check("reset_vs", 32'(vga_vs), 32'd1);
    check("reset_fs", 32'(frame_start), 32'd0);

    // Cells (0,0), (1,1) and (2,1): top-left corner, interior and right edge.
    framebuffer = '0;
    framebuffer[0]  = 1'b1;
    framebuffer[41] = 1'b1;
    framebuffer[42] = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;

    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (vga_hs !== 1'b0 && n < 4 * HT);
    check("first_hs_fall", 32'(n), 32'(2 * (HA + HF) + 2));

    count_until_fs(white);
    check("first_frame_blank", 32'(white), 32'd0);

    // Pixel mapping probes on the frame after the first snapshot
    foreach (probes[i]) begin
      wait_pixel(probes[i].h, probes[i].v);
      check($sformatf("probe_%0d_%0d", probes[i].h, probes[i].v),
            32'({vga_r, vga_g, vga_b}), 32'(probes[i].rgb));
    end

    // hsync width and period
    n = 0;
    while (vga_hs === 1'b0 && n < 4 * HT) begin @(posedge clock); #1; n++; end
    while (vga_hs === 1'b1 && n < 8 * HT) begin @(posedge clock); #1; n++; end
    lo = 0;
    while (vga_hs === 1'b0 && lo < 4 * HT) begin @(posedge clock); #1; lo++; end
    hi = 0;
    while (vga_hs === 1'b1 && hi < 4 * HT) begin @(posedge clock); #1; hi++; end
    check("hs_low_clocks", 32'(lo), 32'(2 * HS));
    check("hs_period", 32'(lo + hi), 32'(2 * HT));

    // vsync width and period
    n = 0;
    while (vga_vs === 1'b0 && n < 2 * FRAME_CLK) begin @(posedge clock); #1; n++; end
    while (vga_vs === 1'b1 && n < 4 * FRAME_CLK) begin @(posedge clock); #1; n++; end
    lo = 0;
    while (vga_vs === 1'b0 && lo < 2 * FRAME_CLK) begin @(posedge clock); #1; lo++; end
    hi = 0;
    while (vga_vs === 1'b1 && hi < 2 * FRAME_CLK) begin @(posedge clock); #1; hi++; end
    check("vs_low_clocks", 32'(lo), 32'(2 * VS * HT));
    check("vs_period", 32'(lo + hi), 32'(FRAME_CLK));

    // frame_start width and spacing
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME_CLK) begin @(posedge clock); #1; n++; end
    @(posedge clock);
    #1;
    check("fs_width", 32'(frame_start), 32'd0);
    n = 1;
    while (frame_start !== 1'b1 && n < 2 * FRAME_CLK) begin @(posedge clock); #1; n++; end
    check("fs_spacing", 32'(n), 32'(FRAME_CLK));

    // Random framebuffer contents changed at random moments
    repeat (4) begin
      for (int i = 0; i < FB_BITS; i++) framebuffer[i] = 1'($urandom_range(0, 1));
      repeat ($urandom_range(50, FRAME_CLK / 2)) @(negedge clock);
    end

    // Tear-free: switch to all-ones mid active area
    framebuffer = '0;
    wait_fs();
    wait_pixel(0, 16);
    framebuffer = '1;
    count_until_fs(white);
    check("tear_current_frame", 32'(white), 32'd0);
    count_until_fs(white);
    check("tear_next_frame", 32'(white), 32'(2 * HA * VA));

    // Mid-frame reset on a white pixel
    wait_pixel(30, 20);
    check("pre_reset_white", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
    check("midreset_hs", 32'(vga_hs), 32'd1);
    check("midreset_vs", 32'(vga_vs), 32'd1);
    check("midreset_fs", 32'(frame_start), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    count_until_fs(white);
    check("post_reset_blank", 32'(white), 32'd0);
    count_until_fs(white);
    check("post_reset_frame", 32'(white), 32'(2 * HA * VA));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
